sr_latch_driver: RTL

- Clocked initiator for a NAND cross-coupled SR latch with active-low S/R inputs.
- Converts single-cycle set/clear commands into clean, non-overlapping, minimum-width low pulses on the latch's S and R inputs.
- Synchronizes the latch's Q/Qbar back into the clock domain and reports completion or error.
- Sits between synchronous control logic and any asynchronous SR storage cell in the design.

---
 rtl/sr_latch_driver.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sr_latch_driver
//  Purpose  : Clocked initiator for a NAND cross-coupled SR latch with
//             active-low S/R inputs. Single-cycle set/clear commands become
//             non-overlapping, fixed-width low pulses on S or R, followed by
//             a both-high guard gap and, optionally, a readback of the
//             synchronized Q/Qbar.
//  Macro    : SR_DRV_READBACK_EN - when defined, adds the CHECK state and the
//             Q/Qbar synchronizer (q_sync live). When undefined, GAP exits
//             straight to IDLE with done, Q/Qbar are ignored, q_sync = 0.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             cmd_valid/ready - command handshake (ready only in IDLE)
//             cmd_set/cmd_clr - command fields, exactly one must be set
//             S, R            - active-low latch drives, straight from flops
//             Q, Qbar         - asynchronous latch outputs
//             done, err       - one-cycle completion / failure pulses
//             q_sync          - synchronized Q
//             busy            - FSM not in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module sr_latch_driver #(
  parameter int PULSE_W   = 4,
  parameter int GAP_W     = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_set,
  input  logic cmd_clr,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Qbar,
  output logic done,
  output logic err,
  output logic q_sync,
  output logic busy
);

  // Parameter range guards: counters are 8 bits and a width of 0 is meaningless.
  if (PULSE_W < 1 || PULSE_W > 255) begin : g_bad_pulse_w
    $error("sr_latch_driver: PULSE_W=%0d outside 1..255", PULSE_W);
  end
  if (GAP_W < 1 || GAP_W > 255) begin : g_bad_gap_w
    $error("sr_latch_driver: GAP_W=%0d outside 1..255", GAP_W);
  end
  if (TIMEOUT_W < 1 || TIMEOUT_W > 255) begin : g_bad_timeout_w
    $error("sr_latch_driver: TIMEOUT_W=%0d outside 1..255", TIMEOUT_W);
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [7:0] C_PULSE_LD = 8'(PULSE_W - 1);
  localparam logic [7:0] C_GAP_LD   = 8'(GAP_W - 1);
`ifdef SR_DRV_READBACK_EN
  localparam logic [1:0] ST_CHECK  = 2'd3;
  localparam logic [7:0] C_TO_LD   = 8'(TIMEOUT_W - 1);
`endif

  logic [1:0] r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_op_set;
  logic       r_s, r_r, r_done, r_err;
  logic       w_s_nxt, w_r_nxt, w_done_nxt, w_err_nxt;
  logic       w_accept, w_legal, w_cnt_zero;

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_legal    = cmd_set ^ cmd_clr;
  assign w_cnt_zero = (r_cnt == 8'd0);

`ifdef SR_DRV_READBACK_EN
  logic r_q_meta, r_q_sync, r_qb_meta, r_qb_sync;
  logic w_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_meta  <= 1'b0;
      r_q_sync  <= 1'b0;
      r_qb_meta <= 1'b0;
      r_qb_sync <= 1'b0;
    end else begin
      r_q_meta  <= Q;
      r_q_sync  <= r_q_meta;
      r_qb_meta <= Qbar;
      r_qb_sync <= r_qb_meta;
    end
  end

  // (1,1) is the forbidden/transient latch state and never counts as a match.
  assign w_match = r_op_set ? (r_q_sync && !r_qb_sync) : (!r_q_sync && r_qb_sync);
  assign q_sync  = r_q_sync;
`else
  logic w_unused_latch;
  assign w_unused_latch = ^{Q, Qbar};
  assign q_sync = 1'b0;
`endif

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_op_set <= 1'b0;
      r_s      <= 1'b1;
      r_r      <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept && w_legal) begin
        r_op_set <= cmd_set;
      end
      r_s    <= w_s_nxt;
      r_r    <= w_r_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Next-state and counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_legal) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = C_PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = C_GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
`ifdef SR_DRV_READBACK_EN
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = C_TO_LD;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
`ifdef SR_DRV_READBACK_EN
      ST_CHECK: begin
        if (w_match || w_cnt_zero) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Next values of the registered outputs. Only a legal command (exactly one
  // of set/clr) ever pulls a line low, so S and R can never be low together.
  always_comb begin
    w_s_nxt    = 1'b1;
    w_r_nxt    = 1'b1;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_legal) begin
            w_s_nxt = !cmd_set;
            w_r_nxt = !cmd_clr;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (!w_cnt_zero) begin
          w_s_nxt = !r_op_set;
          w_r_nxt = r_op_set;
        end
      end
      ST_GAP: begin
`ifndef SR_DRV_READBACK_EN
        w_done_nxt = w_cnt_zero;
`endif
      end
`ifdef SR_DRV_READBACK_EN
      ST_CHECK: begin
        w_done_nxt = w_match;
        w_err_nxt  = !w_match && w_cnt_zero;
      end
`endif
      default: begin
        w_s_nxt = 1'b1;
      end
    endcase
  end

  assign S    = r_s;
  assign R    = r_r;
  assign done = r_done;
  assign err  = r_err;
  assign busy = (r_state != ST_IDLE);
  // Ready returns the cycle after done so a completion is never overlapped.
  assign cmd_ready = (r_state == ST_IDLE) && !r_done;

endmodule
`default_nettype wire
